// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment check for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // True when the access cannot be served: illegal size or lane not aligned to size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lane[0];
      SIZE_W:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store mask/data alignment and load extraction with extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_se,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_shamt  = {i_lane, 3'b000};
  assign o_wdata  = i_wdata << w_shamt;
  assign w_rshift = i_rword >> w_shamt;

  always_comb begin
    o_wmask = 4'b0000;
    o_rdata = 32'h0;
    unique case (i_size)
      SIZE_B: begin
        o_wmask = 4'b0001 << i_lane;
        o_rdata = {{24{i_se & w_rshift[7]}}, w_rshift[7:0]};
      end
      SIZE_H: begin
        o_wmask = 4'b0011 << i_lane;
        o_rdata = {{16{i_se & w_rshift[15]}}, w_rshift[15:0]};
      end
      SIZE_W: begin
        o_wmask = 4'b1111;
        o_rdata = i_rword;
      end
      default: begin
        o_wmask = 4'b0000;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH    = 2 ** (ADDR_W - 2);
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES);

  state_e r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, r_se, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata, r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_access;
  logic              w_live;
  logic              w_we, w_se, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [31:0]       w_wdata, w_rword;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata_sh, w_rdata_ext;

  // With zero wait states the access happens on the accept edge, so the live request is used;
  // otherwise the access always sees the latched copy.
  assign w_live  = (r_state == StIdle);
  assign w_we    = w_live ? req_we    : r_we;
  assign w_addr  = w_live ? req_addr  : r_addr;
  assign w_size  = w_live ? req_size  : r_size;
  assign w_se    = w_live ? req_se    : r_se;
  assign w_wdata = w_live ? req_wdata : r_wdata;

  assign w_rword = r_mem[w_addr[ADDR_W-1:2]];
  assign w_err   = misaligned(w_size, w_addr[1:0]);

  dmem_lane_fmt u_lane_fmt (
    .i_size  (w_size),
    .i_lane  (w_addr[1:0]),
    .i_se    (w_se),
    .i_wdata (w_wdata),
    .i_rword (w_rword),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata_sh),
    .o_rdata (w_rdata_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = 4'd0;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = StResp;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LAST_CNT) begin
          w_access    = 1'b1;
          w_state_nxt = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= SIZE_B;
      r_se    <= 1'b0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == StIdle && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_se    <= req_se;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'h0 : w_rdata_ext;
      end else if (r_state == StResp && rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'h0;
      end
    end
  end

  // Storage is deliberately not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst_ && w_access && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_addr[ADDR_W-1:2]][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, lane formatting, errors, backpressure, reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req_valid, req_ready, req_we, req_se;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W      (8),
    .WAIT_CYCLES (2)
  ) u_dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_se    (req_se),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; inputs are scrambled after accept to prove the request is latched.
  task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                        input logic [1:0] size, input logic se, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int n;
    logic [31:0] first_rdata;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_se    = se;
    req_wdata = wdata;
    step();
    req_we    = ~we;
    req_addr  = ~addr;
    req_size  = 2'b10;
    req_se    = ~se;
    req_wdata = ~wdata;
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_valid && n < 20);
    req_valid = 1'b0;
    check_eq({tag, " latency"}, 32'(n), 32'd3);
    check_eq({tag, " rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    first_rdata = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, " hold valid"}, {31'h0, rsp_valid}, 32'd1);
      check_eq({tag, " hold rdata"}, rsp_rdata, first_rdata);
      check_eq({tag, " hold err"}, {31'h0, rsp_err}, {31'h0, exp_err});
      check_eq({tag, " hold req_ready"}, {31'h0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq({tag, " valid drop"}, {31'h0, rsp_valid}, 32'd0);
    check_eq({tag, " req_ready back"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h0;
    req_size  = 2'b00;
    req_se    = 1'b0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    step();
    step();
    rst_ = 1'b0;
    check_eq("reset req_ready", {31'h0, req_ready}, 32'd1);
    check_eq("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check_eq("reset rsp_rdata", rsp_rdata, 32'h0);
    check_eq("reset rsp_err", {31'h0, rsp_err}, 32'd0);

    do_req("sw 10",   1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("lw 10",   1'b0, 8'h10, 2'b10, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req("lb 13",   1'b0, 8'h13, 2'b00, 1'b1, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    do_req("lbu 13",  1'b0, 8'h13, 2'b00, 1'b0, 32'h0, 32'h000000DE, 1'b0, 0);
    do_req("lh 10",   1'b0, 8'h10, 2'b01, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
    do_req("lhu 12",  1'b0, 8'h12, 2'b01, 1'b0, 32'h0, 32'h0000DEAD, 1'b0, 0);
    do_req("sb 11",   1'b1, 8'h11, 2'b00, 1'b0, 32'hFFFFFF55, 32'h0, 1'b0, 0);
    do_req("lw sb",   1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    do_req("sh 12",   1'b1, 8'h12, 2'b01, 1'b0, 32'hFFFF1234, 32'h0, 1'b0, 0);
    do_req("lw sh",   1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h123455EF, 1'b0, 0);
    do_req("sw 12",   1'b1, 8'h12, 2'b10, 1'b0, 32'h99999999, 32'h0, 1'b1, 0);
    do_req("lw err",  1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h123455EF, 1'b0, 0);
    do_req("lh 11",   1'b0, 8'h11, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1, 0);
    do_req("size 11", 1'b0, 8'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    do_req("bp lw",   1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h123455EF, 1'b0, 5);

    // Known fill at 0x20, then a store aborted by reset during the wait phase.
    do_req("sw 20",   1'b1, 8'h20, 2'b10, 1'b0, 32'h00000000, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_size  = 2'b10;
    req_wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    check_eq("mid req_ready", {31'h0, req_ready}, 32'd0);
    step();
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    check_eq("mid rst req_ready", {31'h0, req_ready}, 32'd1);
    check_eq("mid rst rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check_eq("mid rst rsp_rdata", rsp_rdata, 32'h0);
    check_eq("mid rst rsp_err", {31'h0, rsp_err}, 32'd0);
    do_req("lw 20",   1'b0, 8'h20, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
